// File: rtl/dmem_ctrl_if.sv
// ============================================================================
//  Module      : dmem_ctrl_if
//  Description : CPU-side and memory-side signal bundle for the data-memory
//                controller. "slave" is the controller view, "master" is the
//                view of whatever drives the CPU and memory sides.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_ctrl_if;
    // CPU side
    logic        memRead_in;
    logic        memWrite_in;
    logic [31:0] addr_in;
    logic [31:0] writeData_in;
    logic [31:0] readData_out;
    logic        stall_out;
    logic        misalign_out;
    logic        busErr_out;
    // Memory side
    logic        memReq_out;
    logic        memWe_out;
    logic [29:0] memAddr_out;
    logic [31:0] memWData_out;
    logic        memAck_in;
    logic [31:0] memRData_in;

    modport slave (
        input  memRead_in, memWrite_in, addr_in, writeData_in,
        input  memAck_in, memRData_in,
        output readData_out, stall_out, misalign_out, busErr_out,
        output memReq_out, memWe_out, memAddr_out, memWData_out
    );

    modport master (
        output memRead_in, memWrite_in, addr_in, writeData_in,
        output memAck_in, memRData_in,
        input  readData_out, stall_out, misalign_out, busErr_out,
        input  memReq_out, memWe_out, memAddr_out, memWData_out
    );
endinterface

`default_nettype wire

// File: rtl/dmem_ctrl.sv
// ============================================================================
//  Module      : dmem_ctrl
//  Description : Single-outstanding data-memory access controller. Turns CPU
//                load/store levels into a held memory request, stalls the CPU
//                until ack, rejects misaligned accesses and aborts on timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_ctrl #(
    parameter int unsigned TIMEOUT = 15     // max REQ cycles without ack, 1..255
) (
    input  wire logic  clk,
    input  wire logic  reset,               // asynchronous, active low
    dmem_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Count value seen in the final permitted REQ cycle; an ack in that
    // cycle still wins over the timeout.
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       access;
    logic       aligned;

    assign access  = bus.memRead_in | bus.memWrite_in;
    assign aligned = (bus.addr_in[1:0] == 2'b00);

    // Stall is combinational so the CPU holds PC in the very cycle it asks;
    // gating with reset keeps the CPU free while the controller is held off.
    assign bus.stall_out = reset & (((state == IDLE) & access) | (state == REQ));

    // Main FSM with registered memory-side and status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            wait_cnt         <= 8'd0;
            bus.memReq_out   <= 1'b0;
            bus.memWe_out    <= 1'b0;
            bus.memAddr_out  <= 30'd0;
            bus.memWData_out <= 32'd0;
            bus.readData_out <= 32'd0;
            bus.misalign_out <= 1'b0;
            bus.busErr_out   <= 1'b0;
        end else begin
            // Status pulses live for exactly the DONE cycle.
            bus.misalign_out <= 1'b0;
            bus.busErr_out   <= 1'b0;
            case (state)
                IDLE: begin
                    if (access) begin
                        if (aligned) begin
                            // Write wins when both levels are high.
                            bus.memAddr_out  <= bus.addr_in[31:2];
                            bus.memWData_out <= bus.writeData_in;
                            bus.memWe_out    <= bus.memWrite_in;
                            bus.memReq_out   <= 1'b1;
                            wait_cnt         <= 8'd0;
                            state            <= REQ;
                        end else begin
                            bus.misalign_out <= 1'b1;
                            state            <= DONE;
                        end
                    end
                end
                REQ: begin
                    if (bus.memAck_in) begin
                        if (!bus.memWe_out) begin
                            bus.readData_out <= bus.memRData_in;
                        end
                        bus.memReq_out <= 1'b0;
                        state          <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (wait_cnt == LAST_WAIT) begin
                            bus.memReq_out <= 1'b0;
                            bus.busErr_out <= 1'b1;
                            state          <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    bus.memReq_out <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
// ============================================================================
//  Module      : tb_dmem_ctrl
//  Description : Self-checking bench for dmem_ctrl: table of directed
//                transactions plus hand sequences for reset behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    dmem_ctrl_if bus ();

    dmem_ctrl #(.TIMEOUT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ack_at;   // REQ cycle number carrying the ack, 0 = never
        logic [31:0] rdata;
        logic [29:0] e_addr;
        logic        e_we;
        int          e_req;    // cycles with memReq_out high
        int          e_stall;  // cycles with stall_out high
        logic        e_mis;
        logic        e_be;
        logic [31:0] e_rd;     // readData_out seen in DONE
    } vec_t;

    vec_t vec [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          req_n;
        int          stall_n;
        bit          done;
        bit          bad;
        logic        mis_s;
        logic        be_s;
        logic        rq_s;
        logic [31:0] rd_s;
        req_n = 0; stall_n = 0; done = 0; bad = 0;
        mis_s = 1'b0; be_s = 1'b0; rq_s = 1'b0; rd_s = 32'd0;
        @(negedge clk);
        bus.memRead_in   = v.rd;
        bus.memWrite_in  = v.wr;
        bus.addr_in      = v.addr;
        bus.writeData_in = v.wdata;
        for (int c = 0; c < 40 && !done; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            if (bus.stall_out) begin
                stall_n++;
            end else begin
                done  = 1;
                mis_s = bus.misalign_out;
                be_s  = bus.busErr_out;
                rd_s  = bus.readData_out;
                rq_s  = bus.memReq_out;
            end
            if (bus.memReq_out) begin
                req_n++;
                if (bus.memAddr_out !== v.e_addr || bus.memWe_out !== v.e_we ||
                    bus.memWData_out !== v.wdata)
                    bad = 1;
            end
            bus.memAck_in   = bus.memReq_out && (v.ack_at == req_n);
            bus.memRData_in = v.rdata;
        end
        bus.memRead_in  = 1'b0;
        bus.memWrite_in = 1'b0;
        bus.memAck_in   = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL v%0d done_bound got stall stuck expected release within 40 cycles", idx);
        end
        chk($sformatf("v%0d req_cycles", idx), 32'(req_n), 32'(v.e_req));
        chk($sformatf("v%0d stall_cycles", idx), 32'(stall_n), 32'(v.e_stall));
        chk($sformatf("v%0d misalign", idx), {31'd0, mis_s}, {31'd0, v.e_mis});
        chk($sformatf("v%0d busErr", idx), {31'd0, be_s}, {31'd0, v.e_be});
        chk($sformatf("v%0d readData", idx), rd_s, v.e_rd);
        chk($sformatf("v%0d req_in_done", idx), {31'd0, rq_s}, 32'd0);
        chk($sformatf("v%0d req_fields_stable", idx), {31'd0, bad}, 32'd0);
        // One cycle later the pulses must have dropped and we sit idle.
        @(negedge clk);
        #1;
        chk($sformatf("v%0d pulse_drop", idx),
            {29'd0, bus.misalign_out, bus.busErr_out, bus.stall_out}, 32'd0);
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;

        //          rd    wr    addr           wdata          ack rdata          e_addr         we    req st  mis   be    e_rd
        vec[0] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1,  32'hDEAD_BEEF, 30'h0000_0004, 1'b0, 1,  2,  1'b0, 1'b0, 32'hDEAD_BEEF};
        vec[1] = '{1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 4,  32'hBAD0_BAD0, 30'h0000_0008, 1'b1, 4,  5,  1'b0, 1'b0, 32'hDEAD_BEEF};
        vec[2] = '{1'b1, 1'b0, 32'h0000_0013, 32'h0000_0000, 1,  32'hBAD0_BAD0, 30'h0000_0000, 1'b0, 0,  1,  1'b1, 1'b0, 32'hDEAD_BEEF};
        vec[3] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0000_0000, 0,  32'hBAD0_BAD0, 30'h0000_0010, 1'b0, 15, 16, 1'b0, 1'b1, 32'hDEAD_BEEF};
        vec[4] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0000_0000, 15, 32'hCAFE_F00D, 30'h0000_0011, 1'b0, 15, 16, 1'b0, 1'b0, 32'hCAFE_F00D};
        vec[5] = '{1'b1, 1'b1, 32'h0000_0008, 32'hA5A5_A5A5, 2,  32'hBAD0_BAD0, 30'h0000_0002, 1'b1, 2,  3,  1'b0, 1'b0, 32'hCAFE_F00D};
        vec[6] = '{1'b0, 1'b1, 32'h0000_0022, 32'h5555_AAAA, 1,  32'hBAD0_BAD0, 30'h0000_0000, 1'b0, 0,  1,  1'b1, 1'b0, 32'hCAFE_F00D};
        vec[7] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0F0F_0F0F, 3,  32'h0123_4567, 30'h3FFF_FFFF, 1'b0, 3,  4,  1'b0, 1'b0, 32'h0123_4567};

        bus.memRead_in   = 1'b0;
        bus.memWrite_in  = 1'b0;
        bus.addr_in      = 32'd0;
        bus.writeData_in = 32'd0;
        bus.memAck_in    = 1'b0;
        bus.memRData_in  = 32'd0;
        reset            = 1'b0;

        // Reset state while reset is held low
        #13;
        chk("rst_memReq",   {31'd0, bus.memReq_out},   32'd0);
        chk("rst_memWe",    {31'd0, bus.memWe_out},    32'd0);
        chk("rst_memAddr",  {2'd0, bus.memAddr_out},   32'd0);
        chk("rst_memWData", bus.memWData_out,          32'd0);
        chk("rst_readData", bus.readData_out,          32'd0);
        chk("rst_flags",    {30'd0, bus.misalign_out, bus.busErr_out}, 32'd0);
        chk("rst_stall",    {31'd0, bus.stall_out},    32'd0);
        @(negedge clk);
        reset = 1'b1;

        foreach (vec[i]) run_vec(vec[i], i);

        // Ack while idle must not touch readData_out
        @(negedge clk);
        bus.memAck_in   = 1'b1;
        bus.memRData_in = 32'h9999_9999;
        @(negedge clk);
        bus.memAck_in = 1'b0;
        #1;
        chk("idle_ack_ignored", bus.readData_out, 32'h0123_4567);
        chk("idle_ack_no_req", {31'd0, bus.memReq_out}, 32'd0);

        // Reset asserted in the second REQ cycle
        @(negedge clk);
        bus.memRead_in = 1'b1;
        bus.addr_in    = 32'h0000_0030;
        n = 0;
        for (int c = 0; c < 10 && n < 2; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            if (bus.memReq_out) n++;
        end
        chk("rstreq_reached_req2", 32'(n), 32'd2);
        reset          = 1'b0;
        bus.memRead_in = 1'b0;
        #1;
        chk("rstreq_memReq_drop", {31'd0, bus.memReq_out}, 32'd0);
        chk("rstreq_stall_drop",  {31'd0, bus.stall_out},  32'd0);
        chk("rstreq_readData",    bus.readData_out,        32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        bus.memAck_in   = 1'b1;
        bus.memRData_in = 32'h7777_7777;
        @(negedge clk);
        bus.memAck_in = 1'b0;
        #1;
        chk("late_ack_readData", bus.readData_out, 32'd0);
        chk("late_ack_no_req",   {31'd0, bus.memReq_out}, 32'd0);

        // First access after reset release behaves normally
        vec[0].e_rd = 32'hDEAD_BEEF;
        run_vec(vec[0], 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case anything above waits forever
    initial begin
        #200000;
        $display("FAIL global_timeout got hang expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: DMEM_CTRL

Interface
REQ-001 Parameter TIMEOUT, default 15, SHALL set the maximum number of REQ-state cycles waited for memAck_in before the access is aborted (legal range 1..255).
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 memRead_in  input  1  CPU load request (level, from control unit).
REQ-005 memWrite_in  input  1  CPU store request (level, from control unit).
REQ-006 addr_in  input  32  byte address (ALU result).
REQ-007 writeData_in  input  32  store data (register file data2).
REQ-008 readData_out  output  32  load data to the write-back mux.
REQ-009 stall_out  output  1  high = CPU SHALL hold PC and not commit.
REQ-010 misalign_out  output  1  one-cycle pulse: misaligned access rejected.
REQ-011 busErr_out  output  1  one-cycle pulse: access aborted on timeout.
REQ-012 memReq_out  output  1  memory-side request, held until acknowledged.
REQ-013 memWe_out  output  1  memory-side write enable, valid while memReq_out high.
REQ-014 memAddr_out  output  30  word address (addr_in[31:2]), valid while memReq_out high.
REQ-015 memWData_out  output  32  store data, valid while memReq_out high.
REQ-016 memAck_in  input  1  memory acknowledge; one-cycle pulse, sampled only in REQ.
REQ-017 memRData_in  input  32  load data, valid in the cycle memAck_in is high.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, REQ, DONE.
REQ-019 IDLE: access = memRead_in | memWrite_in; if access and addr_in[1:0]==0, the block SHALL latch addr_in[31:2], writeData_in, and we = memWrite_in, clear the timeout counter, and go to REQ.
REQ-020 IDLE with access and addr_in[1:0]!=0: no memory request; go to DONE with misalign_out=1 in the DONE cycle.
REQ-021 memRead_in and memWrite_in both high SHALL be treated as a write.
REQ-022 REQ: memReq_out=1 with latched memWe_out/memAddr_out/memWData_out held stable; on memAck_in=1 go to DONE, and if read, register memRData_in into readData_out.
REQ-023 REQ: the counter SHALL increment each REQ cycle without ack; when it reaches TIMEOUT with no ack, go to DONE with busErr_out=1 in the DONE cycle and leave readData_out unchanged.
REQ-024 Ack in the same cycle the counter reaches TIMEOUT SHALL count as success (no busErr_out).
REQ-025 DONE: memReq_out=0, stall_out=0, requests ignored; unconditionally go to IDLE next cycle.
REQ-026 stall_out SHALL equal (state==IDLE & access) | (state==REQ), combinationally.
REQ-027 memAck_in in IDLE or DONE SHALL be ignored.
REQ-028 readData_out SHALL hold its value until the next successful read.
REQ-029 Latency: an ack in the first REQ cycle gives a 3-cycle instruction (IDLE stall, REQ stall, DONE release); each extra wait cycle adds one.
REQ-030 misalign_out and busErr_out SHALL be registered, never asserted together, and high for exactly one cycle.

Reset
REQ-031 reset low SHALL immediately force state=IDLE, memReq_out=0, memWe_out=0, memAddr_out=0, memWData_out=0, readData_out=0, misalign_out=0, busErr_out=0, counter=0, independent of clk.
REQ-032 Reset asserted in REQ SHALL drop memReq_out asynchronously; no ack after reset release SHALL update readData_out.
REQ-033 After reset release, the first rising edge SHALL evaluate IDLE normally.

Verification
REQ-034 Load addr 0x00000010, ack on first REQ cycle with memRData_in=0xDEADBEEF -> memAddr_out=0x4, memWe_out=0, stall 1,1,0, readData_out=0xDEADBEEF from DONE.
REQ-035 Store addr 0x00000020, data 0x12345678, ack after 3 wait cycles -> memReq_out high 4 cycles with memWe_out=1, memWData_out stable, stall high 5 cycles total, readData_out unchanged.
REQ-036 Load addr 0x00000013 -> no memReq_out, misalign_out=1 for one cycle, stall 1 then 0.
REQ-037 TIMEOUT=15, load with no ack -> memReq_out high 15 cycles, busErr_out=1 for one cycle, then IDLE; second run with ack on cycle 15 -> success, no busErr_out.
REQ-038 Reset pulled low in 2nd REQ cycle -> memReq_out=0 and stall_out=0 immediately; late ack after release ignored, readData_out=0.
REQ-039 memRead_in=memWrite_in=1 at addr 0x8 -> memWe_out=1, memAddr_out=0x2.
